// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  // Datapath width; fixed at 32 because the shared ripple adder is 32 bits.
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } div_state_e;

  // Two's-complement magnitude of an operand; INT_MIN wraps to itself, which the
  // unsigned datapath then treats as 2^31.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/div_unit_adder.sv
// 32-bit ripple-carry adder shared by the trial subtraction and result negation.
module div_unit_adder
  import div_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            cin_i,
  output logic [XLEN-1:0] y_o,
  output logic            cout_o
);

  logic [XLEN:0] carry;

  // Bit-serial carry chain.
  always_comb begin
    carry    = '0;
    y_o      = '0;
    carry[0] = cin_i;
    for (int i = 0; i < XLEN; i++) begin
      y_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[XLEN];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU with valid/ready handshakes.
module div_unit
  import div_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_dividend,
  input  logic [XLEN-1:0] req_divisor,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] dq_q, dq_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] add_a, add_b, add_y;
  logic            add_cin, add_cout;

  div_op_e         req_op_e;
  logic            req_signed, sa, sb, div0, ovf, early;
  logic [XLEN-1:0] early_res;

  logic [XLEN-1:0] p;
  logic            qb;
  logic [XLEN-1:0] fix_x;
  logic            fix_neg;

  div_unit_adder u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .y_o    (add_y),
    .cout_o (add_cout)
  );

  // Request decode: operand signs and the architecturally defined corner cases.
  always_comb begin
    req_op_e   = div_op_e'(req_op);
    req_signed = (req_op_e == OP_DIV) || (req_op_e == OP_REM);
    sa         = req_signed & req_dividend[XLEN-1];
    sb         = req_signed & req_divisor[XLEN-1];
    div0       = (req_divisor == '0);
    ovf        = req_signed && (req_dividend == INT_MIN) && (req_divisor == ALL_ONES);
    early      = EARLY_OUT && (div0 || ovf);
    if (div0) early_res = req_op[1] ? req_dividend : ALL_ONES;
    else      early_res = req_op[1] ? '0 : INT_MIN;
  end

  // Per-iteration partial remainder and quotient bit; rem[31] covers the 33-bit case.
  always_comb begin
    p       = {rem_q[XLEN-2:0], dq_q[cnt_q]};
    qb      = rem_q[XLEN-1] | add_cout;
    fix_x   = op_q[1] ? rem_q : quo_q;
    fix_neg = op_q[1] ? rneg_q : qneg_q;
  end

  // Next-state, datapath and adder operand selection.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !kill) begin
          op_d   = req_op_e;
          qneg_d = (req_op_e == OP_DIV) && (sa ^ sb) && !div0;
          rneg_d = (req_op_e == OP_REM) && sa;
          dq_d   = abs_val(req_dividend, sa);
          dvs_d  = abs_val(req_divisor, sb);
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = CNT_W'(XLEN - 1);
          if (early) begin
            res_d   = early_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        add_a   = p;
        add_b   = ~dvs_q;
        add_cin = 1'b1;
        rem_d   = qb ? add_y : p;
        quo_d   = {quo_q[XLEN-2:0], qb};
        if (cnt_q == '0) state_d = S_FIXUP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIXUP: begin
        if (fix_neg) begin
          add_a   = ~fix_x;
          add_cin = 1'b1;
          res_d   = add_y;
        end else begin
          res_d   = fix_x;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (kill && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_DIV;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dq_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    resp_valid  = (state_q == S_DONE);
    resp_result = res_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit with EARLY_OUT=1 and EARLY_OUT=0 instances.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, kill, resp_ready;
  logic        rv_eo, rv_ne;
  logic [1:0]  req_op;
  logic [31:0] a_in, b_in;
  logic        rr_eo, rr_ne, vld_eo, vld_ne, bsy_eo, bsy_ne;
  logic [31:0] res_eo, res_ne;

  logic        sel;
  logic        s_ready, s_valid, s_busy;
  logic [31:0] s_res;
  assign s_ready = sel ? rr_ne  : rr_eo;
  assign s_valid = sel ? vld_ne : vld_eo;
  assign s_busy  = sel ? bsy_ne : bsy_eo;
  assign s_res   = sel ? res_ne : res_eo;

  div_unit #(.EARLY_OUT(1'b1)) u_eo (
    .clk(clk), .rst(rst), .req_valid(rv_eo), .req_ready(rr_eo), .req_op(req_op),
    .req_dividend(a_in), .req_divisor(b_in), .kill(kill), .resp_valid(vld_eo),
    .resp_ready(resp_ready), .resp_result(res_eo), .busy(bsy_eo)
  );

  div_unit #(.EARLY_OUT(1'b0)) u_ne (
    .clk(clk), .rst(rst), .req_valid(rv_ne), .req_ready(rr_ne), .req_op(req_op),
    .req_dividend(a_in), .req_divisor(b_in), .kill(kill), .resp_valid(vld_ne),
    .resp_ready(resp_ready), .resp_result(res_ne), .busy(bsy_ne)
  );

  typedef struct packed {
    div_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        early;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op = op;
    a_in   = a;
    b_in   = b;
    if (s) rv_ne = 1'b1;
    else   rv_eo = 1'b1;
    @(negedge clk);
    rv_eo = 1'b0;
    rv_ne = 1'b0;
  endtask

  // One op end to end: latency in cycles from accept cycle to first resp_valid, then result.
  task automatic run_op(input logic s, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input string tag);
    int lat;
    bit seen;
    sel = s;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(s_ready), 32'd1);
    issue(s, op, a, b);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (s_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, s_res, exp);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_vld_after"}, 32'(s_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int hits;
    rst = 1'b1; kill = 1'b0; resp_ready = 1'b0;
    rv_eo = 1'b0; rv_ne = 1'b0; req_op = 2'b00; a_in = '0; b_in = '0; sel = 1'b0;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,        32'd14,         1'b0};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,        32'd2,          1'b0};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[6]  = '{OP_DIVU, 32'h1234,       32'd0,        32'hFFFF_FFFF,  1'b1};
    vecs[7]  = '{OP_REMU, 32'h1234,       32'd0,        32'h1234,       1'b1};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001, 32'd1,         1'b0};
    vecs[11] = '{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE, 1'b0};
    vecs[12] = '{OP_DIV,  32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF,  1'b1};
    vecs[13] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9,  1'b1};

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready_eo", 32'(rr_eo),  32'd1);
    chk("rst_valid_eo", 32'(vld_eo), 32'd0);
    chk("rst_busy_eo",  32'(bsy_eo), 32'd0);
    chk("rst_res_eo",   res_eo,      32'd0);
    chk("rst_ready_ne", 32'(rr_ne),  32'd1);
    chk("rst_valid_ne", 32'(vld_ne), 32'd0);
    chk("rst_res_ne",   res_ne,      32'd0);

    // Vector table on both instances; corner cases take the full path when EARLY_OUT=0.
    for (int i = 0; i < NV; i++) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].early ? 1 : 34, $sformatf("eo_v%0d", i));
      run_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 34,
             $sformatf("ne_v%0d", i));
    end

    // Writeback stall: result and req_ready hold while resp_ready is low.
    sel = 1'b0;
    @(negedge clk);
    issue(1'b0, OP_DIVU, 32'd100, 32'd7);
    lat = 1;
    while (!vld_eo && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_lat", 32'(lat), 32'd34);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_res_%0d", k),   res_eo,          32'd14);
      chk($sformatf("stall_ready_%0d", k), 32'(rr_eo),      32'd0);
      chk($sformatf("stall_vld_%0d", k),   32'(vld_eo),     32'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    chk("stall_hs_ready", 32'(rr_eo), 32'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("stall_post_ready", 32'(rr_eo),  32'd1);
    chk("stall_post_vld",   32'(vld_eo), 32'd0);

    // Kill mid-calculation at T+10.
    @(negedge clk);
    issue(1'b0, OP_DIVU, 32'd100, 32'd7);
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("kill_pre_vld_%0d", k), 32'(vld_eo), 32'd0);
      @(negedge clk);
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready", 32'(rr_eo),  32'd1);
    chk("kill_busy",  32'(bsy_eo), 32'd0);
    chk("kill_vld",   32'(vld_eo), 32'd0);
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      if (vld_eo) hits++;
      @(negedge clk);
    end
    chk("kill_no_resp", 32'(hits), 32'd0);

    // Kill in IDLE blocks a simultaneous request.
    kill  = 1'b1;
    rv_eo = 1'b1;
    req_op = OP_DIVU; a_in = 32'd9; b_in = 32'd3;
    @(negedge clk);
    kill  = 1'b0;
    rv_eo = 1'b0;
    chk("idle_kill_ready", 32'(rr_eo),  32'd1);
    chk("idle_kill_busy",  32'(bsy_eo), 32'd0);

    // Synchronous reset in the middle of an operation.
    sel = 1'b1;
    @(negedge clk);
    issue(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(negedge clk);
    chk("mid_rst_busy_before", 32'(bsy_ne), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(rr_ne),  32'd1);
    chk("mid_rst_vld",   32'(vld_ne), 32'd0);
    chk("mid_rst_res",   res_ne,      32'd0);
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      if (vld_ne) hits++;
      @(negedge clk);
    end
    chk("mid_rst_no_resp", 32'(hits), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
